// File: rtl/speck_pkg.sv
`default_nettype none
// ============================================================
// Module : speck_pkg
// Brief  : Shared state encoding and sizing helpers for the SPECK CBC sequencer
// Rev    : 1.0 - initial release
// ============================================================
package speck_pkg;

  localparam int DEFAULT_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // One cipher block is two SPECK words.
  function automatic int data_width(input int block_size);
    return 2 * block_size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/speck_cbc_decrypt_ctrl_if.sv
`default_nettype none
// ============================================================
// Module : speck_cbc_decrypt_ctrl_if
// Brief  : Valid/ready block stream used for ciphertext in and plaintext out
// Rev    : 1.0 - initial release
// ============================================================
interface speck_cbc_decrypt_ctrl_if #(
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/speck_core_watchdog.sv
`default_nettype none
// ============================================================
// Module : speck_core_watchdog
// Brief  : Saturating cycle counter that flags when the core overstays TIMEOUT
// Rev    : 1.0 - initial release
// ============================================================
module speck_core_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  clear,
  input  wire  enable,
  output logic expired
);

  localparam int                 CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   c_limit = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   c_one   = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != c_limit)) begin
      r_count <= r_count + c_one;
    end
  end

  assign expired = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/speck_cbc_decrypt_ctrl.sv
`default_nettype none
// ============================================================
// Module : speck_cbc_decrypt_ctrl
// Brief  : Drives a SPECK ECB decrypt core one block at a time in CBC or ECB mode
// Rev    : 1.0 - initial release
// ============================================================
module speck_cbc_decrypt_ctrl
  import speck_pkg::*;
#(
  parameter  int BLOCK_SIZE = 64,
  parameter  int KEY_SIZE   = 128,
  parameter  int TIMEOUT    = DEFAULT_TIMEOUT,
  localparam int DATA_W     = data_width(BLOCK_SIZE)
) (
  input  wire                 clk,
  input  wire                 rst_n,
  input  wire                 cfg_load,
  input  wire  [KEY_SIZE-1:0] cfg_key,
  input  wire  [DATA_W-1:0]   cfg_iv,
  input  wire                 cfg_cbc,
  speck_cbc_decrypt_ctrl_if.slave  s,
  speck_cbc_decrypt_ctrl_if.master m,
  output logic                busy,
  output logic                err,
  output logic                core_start,
  output logic [KEY_SIZE-1:0] core_key,
  output logic [DATA_W-1:0]   core_ciphertext,
  input  wire  [DATA_W-1:0]   core_plaintext,
  input  wire                 core_active,
  input  wire                 core_ready
);

  state_t              r_state;
  logic                r_first;
  logic                r_cbc;
  logic                r_busy;
  logic                r_err;
  logic                r_core_start;
  logic                r_m_valid;
  logic [KEY_SIZE-1:0] r_key;
  logic [DATA_W-1:0]   r_ct;
  logic [DATA_W-1:0]   r_chain;
  logic [DATA_W-1:0]   r_out;

  logic                w_wd_clear;
  logic                w_wd_en;
  logic                w_expired;
  logic [DATA_W-1:0]   w_mask;

  assign w_wd_clear = (r_state == ST_START);
  assign w_wd_en    = (r_state == ST_WAIT);
  assign w_mask     = r_cbc ? r_chain : '0;

  // A config load in IDLE takes priority, so the block must not see ready that cycle.
  assign s.ready         = rst_n & (r_state == ST_IDLE) & ~cfg_load;
  assign m.valid         = r_m_valid;
  assign m.data          = r_out;
  assign busy            = r_busy;
  assign err             = r_err;
  assign core_start      = r_core_start;
  assign core_key        = r_key;
  assign core_ciphertext = r_ct;

  speck_core_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_wd_clear),
    .enable  (w_wd_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_first      <= 1'b0;
      r_cbc        <= 1'b1;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_core_start <= 1'b0;
      r_m_valid    <= 1'b0;
      r_key        <= '0;
      r_ct         <= '0;
      r_chain      <= '0;
      r_out        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_load) begin
            r_key   <= cfg_key;
            r_cbc   <= cfg_cbc;
            r_chain <= cfg_iv;
            r_err   <= 1'b0;
          end else if (s.valid) begin
            r_ct         <= s.data;
            r_core_start <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ST_START;
          end
        end
        ST_START: begin
          r_core_start <= 1'b0;
          r_first      <= 1'b1;
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          r_first <= 1'b0;
          // The first WAIT cycle may still carry ready from the previous operation.
          if (!r_first && core_ready) begin
            r_out     <= core_plaintext ^ w_mask;
            r_chain   <= r_ct;
            r_m_valid <= 1'b1;
            r_state   <= ST_OUT;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (m.ready) begin
            r_m_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  a_no_start_while_core_active : assert property (
    @(posedge clk) disable iff (!rst_n) r_core_start |-> !core_active
  );

endmodule
`default_nettype wire

// File: tb/tb_speck_cbc_decrypt_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================
// Module : tb_speck_cbc_decrypt_ctrl
// Brief  : Scoreboard bench for the SPECK CBC sequencer with a behavioural core
// Rev    : 1.0 - initial release
// ============================================================
module tb_speck_cbc_decrypt_ctrl;

  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_load = 1'b0;
  logic [127:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         cfg_cbc = 1'b1;
  logic         busy, err, core_start;
  logic [127:0] core_key, core_ciphertext;
  logic [127:0] core_plaintext = '0;
  logic         core_active = 1'b0;
  logic         core_ready = 1'b0;

  speck_cbc_decrypt_ctrl_if #(.DATA_W(128)) s_if ();
  speck_cbc_decrypt_ctrl_if #(.DATA_W(128)) m_if ();

  speck_cbc_decrypt_ctrl #(
    .BLOCK_SIZE (64),
    .KEY_SIZE   (128),
    .TIMEOUT    (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_load        (cfg_load),
    .cfg_key         (cfg_key),
    .cfg_iv          (cfg_iv),
    .cfg_cbc         (cfg_cbc),
    .s               (s_if.slave),
    .m               (m_if.master),
    .busy            (busy),
    .err             (err),
    .core_start      (core_start),
    .core_key        (core_key),
    .core_ciphertext (core_ciphertext),
    .core_plaintext  (core_plaintext),
    .core_active     (core_active),
    .core_ready      (core_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_accept = 0, n_start = 0;
  int hang = 0, mr_mode = 2;   // mr_mode: 0 random, 1 held low, 2 held high
  logic [127:0] mdl_key = '0, mdl_chain = '0;
  logic         mdl_cbc = 1'b1;
  logic [127:0] exp_q[$];

  // Stand-in for the decrypt core: any keyed bijection is enough to expose key/data routing.
  function automatic logic [127:0] core_f(input logic [127:0] ct, input logic [127:0] key);
    return {ct[63:0], ct[127:64]} ^ key ^ 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual=event missing/out of order required=event in bound", nm);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !m_if.valid) ok = 1;
    end
    if (!ok) flag("wait_idle");
  endtask

  task automatic send(input logic [127:0] ct, input bit expect_out);
    bit ok = 0;
    @(posedge clk); #1;
    s_if.valid = 1'b1;
    s_if.data  = ct;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (s_if.ready) begin
        ok = 1;
        n_accept++;
        if (expect_out) begin
          exp_q.push_back(core_f(ct, mdl_key) ^ (mdl_cbc ? mdl_chain : 128'h0));
          mdl_chain = ct;
        end
        @(posedge clk); #1;
      end
    end
    s_if.valid = 1'b0;
    if (!ok) flag("send_accept");
  endtask

  task automatic cfg(input logic [127:0] key, input logic [127:0] iv, input logic cbc);
    wait_idle();
    @(posedge clk); #1;
    cfg_key = key; cfg_iv = iv; cfg_cbc = cbc; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    mdl_key = key; mdl_chain = iv; mdl_cbc = cbc;
  endtask

  task automatic wait_start();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (core_start) ok = 1;
    end
    if (!ok) flag("wait_core_start");
  endtask

  // Behavioural core: latency 1..5 after the first WAIT cycle, optional stale ready.
  initial begin
    bit pend = 0, stale = 0;
    int lat = 0, wc = 0;
    logic [127:0] pt = '0;
    forever begin
      @(posedge clk); #1;
      core_ready = 1'b0;
      if (!rst_n) begin
        pend = 0; core_active = 1'b0;
      end else begin
        if (pend) begin
          core_active = 1'b1;
          if (wc == 0 && stale) begin core_ready = 1'b1; core_plaintext = ~pt; end
          if (wc == lat) begin
            core_ready = 1'b1; core_plaintext = pt; core_active = 1'b0; pend = 0;
          end
          wc++;
        end
        if (core_start && hang == 0) begin
          pend = 1; wc = 0;
          lat = $urandom_range(1, 5);
          stale = ($urandom_range(0, 2) == 0);
          pt = core_f(core_ciphertext, core_key);
        end
      end
    end
  end

  initial begin
    m_if.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_if.ready = (mr_mode == 0) ? 1'($urandom_range(0, 1)) : (mr_mode == 2);
    end
  end

  initial begin
    bit prev = 0;
    forever begin
      @(negedge clk);
      if (rst_n && core_start) begin
        n_start++;
        if (prev) flag("core_start_single_cycle");
      end
      prev = rst_n && core_start;
    end
  end

  // Output monitor: pops the scoreboard on each plaintext handshake.
  initial begin
    bit stall = 0;
    logic [127:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0;
      end else if (m_if.valid) begin
        if (stall) chk("m_data_stable", m_if.data, held);
        if (m_if.ready) begin
          if (exp_q.size() == 0) flag("unexpected_output");
          else chk("m_data", m_if.data, exp_q.pop_front());
          stall = 0;
        end else begin
          stall = 1; held = m_if.data;
        end
      end else begin
        if (stall) flag("m_valid_dropped");
        stall = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=no finish required=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int s0;
    logic [127:0] hold;
    bit ok;
    s_if.valid = 1'b0;
    s_if.data  = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_outputs_zero", 128'(|{s_if.ready, m_if.valid, m_if.data, busy, err,
                                   core_start, core_key, core_ciphertext}), 128'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 128'(s_if.ready), 128'h1);
    chk("rst_m_valid", 128'(m_if.valid), 128'h0);

    // ECB single block.
    mr_mode = 2;
    cfg(128'h472d4b6150645367753778214125442a, 128'h0, 1'b0);
    s0 = n_start;
    send(128'hff2d4b6150645364353678214125442a, 1);
    wait_idle();
    chk("ecb_one_start", 128'(n_start - s0), 128'h1);

    // CBC two blocks.
    cfg(128'h0f0e0d0c0b0a09080706050403020100, 128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    send(128'h1111222233334444555566667777aaaa, 1);
    send(128'h9999888877776666555544443333bbbb, 1);
    wait_idle();

    // Backpressure: m_ready low for 20 cycles.
    mr_mode = 1;
    s0 = n_start;
    send(128'hdeadbeef0123456789abcdeffedcba98, 1);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (m_if.valid) ok = 1;
    end
    if (!ok) flag("bp_m_valid");
    hold = m_if.data;
    repeat (20) begin
      @(negedge clk);
      chk("bp_m_data", m_if.data, hold);
      chk("bp_s_ready", 128'(s_if.ready), 128'h0);
    end
    chk("bp_one_start", 128'(n_start - s0), 128'h1);
    mr_mode = 2;
    wait_idle();

    // Timeout: core never answers.
    hang = 1;
    send(128'h0badc0de0badc0de0badc0de0badc0de, 0);
    wait_start();
    repeat (15) @(negedge clk);
    chk("to_err_early", 128'(err), 128'h0);
    repeat (2) @(negedge clk);
    chk("to_err_set", 128'(err), 128'h1);
    chk("to_busy_clear", 128'(busy), 128'h0);
    hang = 0;
    send(128'h13579bdf2468ace013579bdf2468ace0, 1);
    wait_idle();
    chk("to_err_sticky", 128'(err), 128'h1);

    // Simultaneous cfg_load and s_valid.
    @(posedge clk); #1;
    cfg_key = 128'hcafef00dcafef00dcafef00dcafef00d;
    cfg_iv  = 128'hffeeddccbbaa99887766554433221100;
    cfg_cbc = 1'b1; cfg_load = 1'b1;
    s_if.valid = 1'b1; s_if.data = 128'h0123456789abcdef0011223344556677;
    @(negedge clk);
    chk("sim_s_ready_low", 128'(s_if.ready), 128'h0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    mdl_key = cfg_key; mdl_chain = cfg_iv; mdl_cbc = 1'b1;
    @(negedge clk);
    chk("sim_s_ready_next", 128'(s_if.ready), 128'h1);
    if (s_if.ready) begin
      n_accept++;
      exp_q.push_back(core_f(s_if.data, mdl_key) ^ mdl_chain);
      mdl_chain = s_if.data;
    end
    @(posedge clk); #1 s_if.valid = 1'b0;
    wait_idle();
    chk("cfg_clears_err", 128'(err), 128'h0);

    // Reset in the middle of WAIT.
    send(128'h5555aaaa5555aaaa5555aaaa5555aaaa, 1);
    wait_start();
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_zero", 128'(|{s_if.ready, m_if.valid, m_if.data, busy, err,
                               core_start, core_key, core_ciphertext}), 128'h0);
    exp_q.delete();
    mdl_key = '0; mdl_chain = '0; mdl_cbc = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_s_ready", 128'(s_if.ready), 128'h1);
    chk("rst_mid_m_valid", 128'(m_if.valid), 128'h0);
    send(128'h00000000ffffffff00000000ffffffff, 1);
    wait_idle();

    // Randomized traffic with periodic reconfiguration.
    mr_mode = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 8 == 0)
        cfg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)));
      send({$urandom, $urandom, $urandom, $urandom}, 1);
    end
    wait_idle();
    chk("start_count", 128'(n_start), 128'(n_accept));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/speck_cbc_decrypt_ctrl.md
Name: speck_cbc_decrypt_ctrl

Overview:
- Sequencer that runs the SPECK ECB decryption core in CBC mode over a stream of ciphertext blocks.
- Accepts ciphertext blocks on a valid/ready input stream, issues one core start per block, waits for core completion, XORs the core output with the chaining value (IV or previous ciphertext), and presents plaintext on a valid/ready output stream.
- Sits between the bus/DMA front end and the decrypt_ECB instance; owns the core's start, key and ciphertext inputs.

Parameters:
- BLOCK_SIZE, 64, SPECK word size; data path width DATA_W = 2*BLOCK_SIZE (localparam).
- KEY_SIZE, 128, key width forwarded to the core.
- TIMEOUT, 1023, maximum cycles waiting for core_ready before flagging an error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cfg_load  in  1  latch cfg_key/cfg_iv/cfg_cbc; honoured only in IDLE.
- cfg_key  in  KEY_SIZE  key.
- cfg_iv  in  DATA_W  initial chaining value.
- cfg_cbc  in  1  1 = CBC, 0 = plain ECB (no XOR).
- s_valid  in  1  ciphertext block valid.
- s_ready  out  1  controller can accept a block.
- s_data  in  DATA_W  ciphertext block.
- m_valid  out  1  plaintext block valid.
- m_ready  in  1  downstream accepts plaintext.
- m_data  out  DATA_W  plaintext block.
- busy  out  1  a block is in flight (state != IDLE).
- err  out  1  sticky timeout flag; cleared by cfg_load or reset.
- core_start  out  1  one-cycle start pulse to the core.
- core_key  out  KEY_SIZE  registered key.
- core_ciphertext  out  DATA_W  registered current ciphertext.
- core_plaintext  in  DATA_W  core output.
- core_active  in  1  core running (monitor only; not used for sequencing).
- core_ready  in  1  core output valid, high at least one cycle.

Behaviour:
- Reset values: all outputs 0. Key, IV, chain and ciphertext registers are 0; cfg_cbc register is 1; state is IDLE; timeout counter is 0. Reset mid-block abandons the block, with no output produced.
- FSM:
  - IDLE: s_ready=1. On s_valid, latch s_data into cur_ct, go to START. On cfg_load (s_valid low), latch the config, chain<=cfg_iv, err<=0. If both are high in the same cycle, cfg_load wins, s_ready is forced 0 that cycle, and the block is not consumed.
  - START: core_start=1 for exactly this cycle; counter<=0; go to WAIT.
  - WAIT: core_ready is ignored on the first WAIT cycle (guards a stale ready). From the second cycle, core_ready=1 gives out_reg<=core_plaintext XOR (cbc ? chain : 0), chain<=cur_ct, then go to OUT. Each cycle without core_ready increments the counter. When counter==TIMEOUT: err<=1, block dropped, chain unchanged, go to IDLE.
  - OUT: m_valid=1 and m_data=out_reg, held stable until m_ready. On m_ready go to IDLE, so s_ready is high the next cycle.
- No pipelining: one block in flight. Throughput is 1 block per (core latency + 3) cycles minimum.
- s_ready=0 outside IDLE. cfg_load outside IDLE is ignored and not queued.
- core_key and core_ciphertext are driven from registers and are stable from START through WAIT.
- err does not block operation; new blocks are still accepted.

Decomposition:
- Package speck_pkg: state encoding (IDLE/START/WAIT/OUT, 2-bit), DATA_W derivation helper, default TIMEOUT.
- Sub-module speck_core_watchdog: cycle counter with clear/enable/expired, width clog2(TIMEOUT+1).
- The core itself is instantiated one level up, not inside this block.

Test Plan:
- Reset, with rst_n low mid-WAIT -> all outputs 0 immediately; after release s_ready=1, no m_valid.
- ECB, cfg_cbc=0, key 0x472d4b61506453677537782141254... per core vector, one block 0xff2d4b6150645364353678214125442a -> single core_start pulse; m_data equals core_plaintext; m_valid held until m_ready.
- CBC, IV=0x000102030405060708090a0b0c0d0e0f, two blocks C1, C2, core model returning P' -> m_data1=P'1^IV, m_data2=P'2^C1.
- Backpressure, m_ready low 20 cycles -> m_data stable, s_ready=0 throughout, no second core_start.
- Timeout, TIMEOUT=15, core_ready never asserted -> err=1 at 16 cycles after START; chain unchanged; next block decrypts correctly.
- Simultaneous cfg_load and s_valid in IDLE -> config latched, block not consumed (s_ready=0); block is accepted the next cycle using the new IV.
